// File: rtl/adc_scan_arbiter.sv
// Round-robin sharing of one SPI ADC capture core between NREQ requesters.
// Grants a start, waits for done or timeout, returns a tagged response, then idles for a guard gap.
module adc_scan_arbiter #(
    parameter int NREQ    = 4,
    parameter int CHW     = 4,
    parameter int DW      = 16,
    parameter int TIMEOUT = 1024,
    parameter int T_GAP   = 4,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CHW-1:0]   req_ch,
    output logic [NREQ-1:0]       gnt,
    output logic                  adc_start,
    output logic [CHW-1:0]        adc_ch,
    input  logic                  adc_busy,
    input  logic                  adc_done,
    input  logic [DW-1:0]         adc_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [DW-1:0]         rsp_data,
    output logic                  rsp_err,
    output logic                  idle
);
    localparam int TW = $clog2((TIMEOUT > T_GAP) ? TIMEOUT : T_GAP + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, GAP} state_t;

    state_t          state_q;
    logic [IDW-1:0]  rr_q;
    logic [TW-1:0]   timer_q;
    logic [NREQ-1:0] gnt_q;
    logic            start_q;
    logic [CHW-1:0]  ch_q;
    logic            vld_q;
    logic [IDW-1:0]  id_q;
    logic [DW-1:0]   data_q;
    logic            err_q;
    logic            idle_q;

    logic            win_vld;
    logic [IDW-1:0]  win_id;
    logic [IDW-1:0]  nxt_ptr;
    logic [IDW:0]    sum;

    // Scan from rr_q upward with wrap; first pending request wins.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        sum     = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_q} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
            if (!win_vld && req[sum[IDW-1:0]]) begin
                win_vld = 1'b1;
                win_id  = sum[IDW-1:0];
            end
        end
    end

    assign nxt_ptr = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            timer_q <= '0;
            gnt_q   <= '0;
            start_q <= 1'b0;
            ch_q    <= '0;
            vld_q   <= 1'b0;
            id_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            gnt_q   <= '0;
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_vld && !adc_busy) begin
                        gnt_q[win_id] <= 1'b1;
                        start_q       <= 1'b1;
                        ch_q          <= req_ch[int'(win_id)*CHW +: CHW];
                        id_q          <= win_id;
                        rr_q          <= nxt_ptr;
                        timer_q       <= '0;
                        idle_q        <= 1'b0;
                        state_q       <= WAIT;
                    end
                end
                WAIT: begin
                    timer_q <= timer_q + 1'b1;
                    // A done landing on the timeout cycle still delivers its data.
                    if (adc_done) begin
                        data_q  <= adc_data;
                        err_q   <= 1'b0;
                        vld_q   <= 1'b1;
                        state_q <= RESP;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        data_q  <= '0;
                        err_q   <= 1'b1;
                        vld_q   <= 1'b1;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        vld_q   <= 1'b0;
                        timer_q <= '0;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    if (timer_q == TW'(T_GAP - 1)) begin
                        idle_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    idle_q  <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign adc_start = start_q;
    assign adc_ch    = ch_q;
    assign rsp_valid = vld_q;
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;
    assign idle      = idle_q;

endmodule

// File: tb/tb_adc_scan_arbiter.sv
// Directed bench for adc_scan_arbiter: responses are predicted into a queue at grant
// time and popped on each rsp_valid&rsp_ready handshake.
module tb_adc_scan_arbiter;
    localparam int NREQ    = 4;
    localparam int CHW     = 4;
    localparam int DW      = 16;
    localparam int TIMEOUT = 1024;
    localparam int T_GAP   = 4;
    localparam int IDW     = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*CHW-1:0] req_ch;
    logic [NREQ-1:0]     gnt;
    logic                adc_start;
    logic [CHW-1:0]      adc_ch;
    logic                adc_busy;
    logic                adc_done;
    logic [DW-1:0]       adc_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [DW-1:0]       rsp_data;
    logic                rsp_err;
    logic                idle;

    typedef struct {
        int          id;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   last_start = 0;
    int   n;

    adc_scan_arbiter #(.NREQ(NREQ), .CHW(CHW), .DW(DW), .TIMEOUT(TIMEOUT), .T_GAP(T_GAP)) dut (
        .clk(clk), .rst(rst), .req(req), .req_ch(req_ch), .gnt(gnt),
        .adc_start(adc_start), .adc_ch(adc_ch), .adc_busy(adc_busy),
        .adc_done(adc_done), .adc_data(adc_data), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [15:0] d, input logic e);
        exp_t x;
        x.id = id; x.data = d; x.err = e;
        sb.push_back(x);
    endtask

    // Outputs are stable between edges, so a handshake seen here is the one the next edge takes.
    task automatic step();
        exp_t x;
        if (rsp_valid && rsp_ready) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("sb_id", 32'(rsp_id), x.id);
                chk("sb_data", 32'(rsp_data), 32'(x.data));
                chk("sb_err", 32'(rsp_err), 32'(x.err));
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_start(input int lim);
        int k = 0;
        while (!adc_start && k < lim) begin step(); k++; end
        chk("start_seen", 32'(adc_start), 32'd1);
    endtask

    task automatic wait_idle(input int lim);
        int k = 0;
        while (!idle && k < lim) begin step(); k++; end
        chk("idle_reached", 32'(idle), 32'd1);
    endtask

    initial begin
        rst = 1'b1; req = '0; req_ch = '0; adc_busy = 1'b0; adc_done = 1'b0;
        adc_data = '0; rsp_ready = 1'b1;
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_start", 32'(adc_start), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        rst = 1'b0;
        step();

        // Reset in the middle of WAIT, then a late done
        req = 4'b0100; req_ch = 16'h0300;
        step();
        chk("r_gnt", 32'(gnt), 32'h4);
        chk("r_start", 32'(adc_start), 32'd1);
        chk("r_ch", 32'(adc_ch), 32'd3);
        chk("r_id", 32'(rsp_id), 32'd2);
        req = '0;
        repeat (5) step();
        rst = 1'b1;
        #1;
        chk("r_async_gnt", 32'(gnt), 32'd0);
        chk("r_async_start", 32'(adc_start), 32'd0);
        chk("r_async_ch", 32'(adc_ch), 32'd0);
        chk("r_async_id", 32'(rsp_id), 32'd0);
        chk("r_async_data", 32'(rsp_data), 32'd0);
        chk("r_async_err", 32'(rsp_err), 32'd0);
        chk("r_async_valid", 32'(rsp_valid), 32'd0);
        chk("r_async_idle", 32'(idle), 32'd1);
        step(); step();
        rst = 1'b0;
        adc_done = 1'b1; adc_data = 16'hDEAD;
        step();
        adc_done = 1'b0;
        repeat (3) begin
            step();
            chk("r_late_done_valid", 32'(rsp_valid), 32'd0);
        end
        chk("r_late_done_idle", 32'(idle), 32'd1);

        // Round robin with all four requesting; first grant to 0 shows rr_ptr reset
        req = 4'hF; req_ch = 16'h7654; rsp_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            wait_start(40);
            chk("rr_gnt", 32'(gnt), 32'd1 << (g % 4));
            chk("rr_ch", 32'(adc_ch), (g % 4) + 4);
            if (g > 0) chk("rr_spacing", cyc - last_start, 10 + 1 + 1 + T_GAP + 1);
            last_start = cyc;
            if (g == 4) req = '0;
            push_exp(g % 4, 16'hC000 + 16'(g), 1'b0);
            repeat (10) step();
            adc_done = 1'b1; adc_data = 16'hC000 + 16'(g);
            step();
            adc_done = 1'b0;
        end
        wait_idle(40);

        // Single request, done after 40 cycles
        req = 4'b0001; req_ch = 16'h0005;
        push_exp(0, 16'hA5C3, 1'b0);
        step();
        chk("s_gnt", 32'(gnt), 32'h1);
        chk("s_start", 32'(adc_start), 32'd1);
        chk("s_ch", 32'(adc_ch), 32'd5);
        req = '0;
        step();
        chk("s_gnt_pulse", 32'(gnt), 32'd0);
        chk("s_start_pulse", 32'(adc_start), 32'd0);
        repeat (39) step();
        adc_done = 1'b1; adc_data = 16'hA5C3;
        step();
        adc_done = 1'b0;
        chk("s_valid", 32'(rsp_valid), 32'd1);
        chk("s_id", 32'(rsp_id), 32'd0);
        chk("s_data", 32'(rsp_data), 32'hA5C3);
        chk("s_err", 32'(rsp_err), 32'd0);
        wait_idle(20);

        // Timeout with no done
        req = 4'b0010; req_ch = 16'h0090;
        push_exp(1, 16'h0000, 1'b1);
        step();
        chk("t_gnt", 32'(gnt), 32'h2);
        chk("t_ch", 32'(adc_ch), 32'd9);
        req = '0;
        n = 0;
        while (!rsp_valid && n < TIMEOUT + 10) begin step(); n++; end
        chk("t_latency", n, TIMEOUT);
        chk("t_err", 32'(rsp_err), 32'd1);
        chk("t_data", 32'(rsp_data), 32'd0);
        chk("t_id", 32'(rsp_id), 32'd1);
        wait_idle(20);

        // Done on the very cycle the timeout would fire
        req = 4'b1000; req_ch = 16'h2000;
        push_exp(3, 16'hBEEF, 1'b0);
        step();
        chk("c_gnt", 32'(gnt), 32'h8);
        req = '0;
        repeat (TIMEOUT - 1) step();
        adc_done = 1'b1; adc_data = 16'hBEEF;
        step();
        adc_done = 1'b0;
        chk("c_valid", 32'(rsp_valid), 32'd1);
        chk("c_err", 32'(rsp_err), 32'd0);
        chk("c_data", 32'(rsp_data), 32'hBEEF);
        wait_idle(20);

        // Backpressure, then busy holding off the next start
        rsp_ready = 1'b0;
        req = 4'b0100; req_ch = 16'h0100;
        push_exp(2, 16'h1234, 1'b0);
        step();
        chk("b_gnt", 32'(gnt), 32'h4);
        req = 4'b0001; req_ch = 16'h000A;
        repeat (3) step();
        adc_done = 1'b1; adc_data = 16'h1234;
        step();
        adc_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("b_valid", 32'(rsp_valid), 32'd1);
            chk("b_data", 32'(rsp_data), 32'h1234);
            chk("b_id", 32'(rsp_id), 32'd2);
            chk("b_err", 32'(rsp_err), 32'd0);
            chk("b_gnt", 32'(gnt), 32'd0);
            chk("b_start", 32'(adc_start), 32'd0);
            step();
        end
        adc_busy = 1'b1; rsp_ready = 1'b1;
        step();
        for (int i = 0; i < T_GAP + 6; i++) begin
            step();
            chk("busy_no_start", 32'(adc_start), 32'd0);
        end
        chk("busy_idle", 32'(idle), 32'd1);
        adc_busy = 1'b0;
        push_exp(0, 16'h0F0F, 1'b0);
        step();
        chk("busy_start", 32'(adc_start), 32'd1);
        chk("busy_gnt", 32'(gnt), 32'h1);
        chk("busy_ch", 32'(adc_ch), 32'hA);
        req = '0;
        repeat (2) step();
        adc_done = 1'b1; adc_data = 16'h0F0F;
        step();
        adc_done = 1'b0;
        wait_idle(20);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adc_scan_arbiter.md
Name: adc_scan_arbiter

Overview:
- Shares one SPI ADC front-end (serial capture core: one conversion per start, 16-bit result) between NREQ requesters.
- Round-robin arbiter picks one pending request and drives the core's start/channel inputs.
- Waits for the core's done pulse or a timeout, then returns the result tagged with the requester id over a valid/ready response port.
- Enforces a guard gap before the next conversion.

Parameters:
NREQ, 4, number of requesters (2..8)
CHW, 4, channel select width
DW, 16, ADC result width
TIMEOUT, 1024, max cycles in WAIT before error response (>=2)
T_GAP, 4, idle guard cycles after each response (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
req  in  NREQ  per-requester conversion request, level, held until gnt
req_ch  in  NREQ*CHW  channel for requester i at bits [i*CHW +: CHW]
gnt  out  NREQ  one-hot one-cycle grant pulse
adc_start  out  1  one-cycle start pulse to ADC core
adc_ch  out  CHW  channel to ADC core, stable from start until done/timeout
adc_busy  in  1  ADC core busy; no start issued while high
adc_done  in  1  one-cycle conversion-complete pulse
adc_data  in  DW  result, valid when adc_done=1
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted when rsp_valid&rsp_ready
rsp_id  out  $clog2(NREQ)  requester index of response
rsp_data  out  DW  conversion result (0 on error)
rsp_err  out  1  1 = timeout, no result
idle  out  1  1 in IDLE state

Behaviour:
- Reset (async, any state, including mid-conversion):
  - state=IDLE, rr_ptr=0, timer=0.
  - gnt=0, adc_start=0, adc_ch=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, idle=1.
  - A conversion in flight is abandoned; a late adc_done after reset is ignored.
- States: IDLE, WAIT, RESP, GAP. All outputs registered.
- IDLE:
  - Condition: (|req) && !adc_busy.
  - Winner w = first set req bit scanning rr_ptr, rr_ptr+1, ... wrapping mod NREQ.
  - Next edge: gnt[w]=1 and adc_start=1 for exactly 1 cycle; adc_ch=req_ch[w]; rsp_id=w; rr_ptr=(w+1) mod NREQ; timer=0; state=WAIT.
  - Latency: req assertion to gnt/adc_start is 1 cycle.
- WAIT:
  - timer increments each cycle.
  - adc_done=1: rsp_data=adc_data, rsp_err=0, rsp_valid=1 next cycle, state=RESP.
  - Else timer==TIMEOUT-1: rsp_data=0, rsp_err=1, rsp_valid=1, state=RESP.
  - adc_done on the same cycle as timeout: done wins, rsp_err=0.
- RESP:
  - rsp_valid, rsp_id, rsp_data and rsp_err are held stable until rsp_valid&rsp_ready.
  - On that cycle: rsp_valid=0 next edge, timer=0, state=GAP.
  - No new grant while in RESP (backpressure stalls arbitration).
- GAP: T_GAP cycles, then IDLE. Minimum handshake-to-next-adc_start is T_GAP+1 cycles.
- adc_done outside WAIT is ignored.
- req dropped before grant is simply not considered.
- Requester i must deassert req in the cycle after gnt[i]; if still high, it is treated as a new request.
- rr_ptr updates only on grant.
- adc_ch and rsp_id keep their last values outside WAIT/RESP.
- idle=1 only in IDLE state.

Test Plan:
- Reset mid-WAIT:
  - Grant req[2], assert rst at cycle 5 of WAIT, then pulse adc_done.
  - Required: all outputs 0 immediately, no rsp_valid, rr_ptr=0.
- Single request:
  - req=0001, req_ch[3:0]=5, adc_done with adc_data=16'hA5C3 at 40 cycles.
  - Required: gnt=0001 and adc_start 1 cycle after req, adc_ch=5, then rsp_valid with rsp_id=0, rsp_data=16'hA5C3, rsp_err=0.
- Round robin:
  - req=1111 held continuously, rsp_ready=1, core returns done after 10 cycles.
  - Required: grant order 0,1,2,3,0; successive adc_start pulses spaced by 10+1+1+T_GAP+1 cycles.
- Timeout:
  - Grant req[1], never pulse adc_done.
  - Required: rsp_valid exactly TIMEOUT cycles after adc_start, with rsp_err=1, rsp_data=0, rsp_id=1.
  - Done/timeout coincidence: rsp_err=0, data passed through.
- Backpressure and busy:
  - Hold rsp_ready=0 for 20 cycles.
  - Required: response fields stable, no gnt, no adc_start.
  - Then adc_busy=1 while back in IDLE with req pending: no start until adc_busy falls, start 1 cycle after it falls.
